// File: rtl/mem_bus_if.sv
// Processor data-memory bus between the memory control unit and the memory responder.
interface mem_bus_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              req;
  logic              RW;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              ack;
  logic              busy;
  logic              err;

  modport master (
    output req, RW, addr, data_in,
    input  data_out, ack, busy, err
  );

  modport slave (
    input  req, RW, addr, data_in,
    output data_out, ack, busy, err
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: latches a request, waits WAIT_STATES cycles,
// performs the word access on an internal RAM and pulses ack for one cycle.
module mem_bus_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic     clk,
  input  logic     rst,
  mem_bus_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AW1   = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range_c;
  logic              mem_we_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] rd_word_c;

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range_c = AW1'(addr_q) < AW1'(DEPTH);
  assign idx_c      = addr_q[IDX_W-1:0];
  assign rd_word_c  = mem[idx_c];
  assign mem_we_c   = (state_q == S_WAIT) && (cnt_q == '0) && rw_q && in_range_c;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    data_d     = data_q;
    data_out_d = data_out_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          rw_d    = bus.RW;
          addr_d  = bus.addr;
          data_d  = bus.data_in;
          cnt_d   = CNT_W'(WAIT_STATES);
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ack_d   = 1'b1;
          err_d   = !in_range_c;
          state_d = S_RESP;
          if (!rw_q) data_out_d = in_range_c ? rd_word_c : '0;
        end
      end
      S_RESP: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // RAM is not reset; reset forces IDLE so an abandoned write never commits.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_c] <= data_q;
  end

  assign bus.data_out = data_out_q;
  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: one DUT with 2 wait states / 200 words,
// one with 0 wait states / 256 words.
module tb_mem_bus_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_if #(.DATA_W(32), .ADDR_W(8)) b2 ();
  mem_bus_if #(.DATA_W(32), .ADDR_W(8)) b0 ();

  mem_bus_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(b2));
  mem_bus_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0));

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected response whenever a DUT acks.
  always @(negedge clk) begin
    if (b2.ack) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_data_out", b2.data_out, e.d);
        chk("dut2_err", 32'(b2.err), 32'(e.e));
      end
    end
  end

  always @(negedge clk) begin
    if (b0.ack) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0_data_out", b0.data_out, e.d);
        chk("dut0_err", 32'(b0.err), 32'(e.e));
      end
    end
  end

  task automatic txn(input int sel, input logic rw, input logic [7:0] a,
                     input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    int   n;
    int   lat;
    logic ackv;
    e.d = exp_d;
    e.e = exp_e;
    lat = (sel == 0) ? 1 : 3;
    @(negedge clk);
    if (sel == 0) begin
      q0.push_back(e);
      b0.req = 1'b1; b0.RW = rw; b0.addr = a; b0.data_in = d;
    end else begin
      q2.push_back(e);
      b2.req = 1'b1; b2.RW = rw; b2.addr = a; b2.data_in = d;
    end
    @(posedge clk); #1;
    if (sel == 0) begin
      b0.req = 1'b0;
      chk("dut0_busy_rise", 32'(b0.busy), 32'd1);
    end else begin
      b2.req = 1'b0;
      chk("dut2_busy_rise", 32'(b2.busy), 32'd1);
    end
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      ackv = (sel == 0) ? b0.ack : b2.ack;
      if (ackv) break;
    end
    chk("ack_latency", 32'(n), 32'(lat));
    @(posedge clk); #1;
    chk("ack_pulse_end", 32'((sel == 0) ? b0.ack : b2.ack), 32'd0);
    chk("busy_fall", 32'((sel == 0) ? b0.busy : b2.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ack_a;
    int ack_b;
    b2.req = 1'b0; b2.RW = 1'b0; b2.addr = '0; b2.data_in = '0;
    b0.req = 1'b0; b0.RW = 1'b0; b0.addr = '0; b0.data_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_data_out", b2.data_out, 32'd0);
    chk("rst_ack", 32'(b2.ack), 32'd0);
    chk("rst_busy", 32'(b2.busy), 32'd0);
    chk("rst_err", 32'(b2.err), 32'd0);
    rst = 1'b0;

    // Basic write then read with two wait states.
    txn(2, 1'b1, 8'd5, 32'hDEADBEEF, 32'h0, 1'b0);
    txn(2, 1'b0, 8'd5, 32'h0, 32'hDEADBEEF, 1'b0);

    // Zero wait states; read data holds across a later write.
    txn(0, 1'b1, 8'd5, 32'hDEADBEEF, 32'h0, 1'b0);
    txn(0, 1'b0, 8'd5, 32'h0, 32'hDEADBEEF, 1'b0);
    txn(0, 1'b1, 8'd6, 32'h12345678, 32'hDEADBEEF, 1'b0);
    repeat (2) @(negedge clk);
    chk("dut0_data_hold", b0.data_out, 32'hDEADBEEF);

    // Out-of-range accesses.
    txn(2, 1'b1, 8'd199, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0);
    txn(2, 1'b1, 8'd210, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1);
    txn(2, 1'b0, 8'd210, 32'h0, 32'h0, 1'b1);
    txn(2, 1'b0, 8'd199, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Reset during a write abandons it.
    txn(2, 1'b1, 8'd7, 32'h11111111, 32'hA5A5A5A5, 1'b0);
    @(negedge clk);
    b2.req = 1'b1; b2.RW = 1'b1; b2.addr = 8'd7; b2.data_in = 32'h22222222;
    @(posedge clk); #1;
    b2.req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(b2.busy), 32'd0);
    chk("abort_ack", 32'(b2.ack), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_data_out", b2.data_out, 32'd0);
    rst = 1'b0;
    txn(2, 1'b0, 8'd7, 32'h0, 32'h11111111, 1'b0);

    // req held high: address change mid-transaction ignored, acks 5 cycles apart.
    ack_a = 0;
    ack_b = 0;
    @(negedge clk);
    begin
      exp_t e;
      e.d = 32'h11111111;
      e.e = 1'b0;
      q2.push_back(e);
      q2.push_back(e);
    end
    b2.req = 1'b1; b2.RW = 1'b1; b2.addr = 8'd8; b2.data_in = 32'hAAAA0008;
    @(posedge clk);
    @(negedge clk);
    b2.addr = 8'd9; b2.data_in = 32'hBBBB0009;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (b2.ack) begin
        if (ack_a == 0) ack_a = i;
        else if (ack_b == 0) ack_b = i;
      end
      if (i == 5) b2.req = 1'b0;
    end
    chk("b2b_first_ack", 32'(ack_a), 32'd3);
    chk("b2b_spacing", 32'(ack_b - ack_a), 32'd5);
    chk("b2b_idle_busy", 32'(b2.busy), 32'd0);
    txn(2, 1'b0, 8'd8, 32'h0, 32'hAAAA0008, 1'b0);
    txn(2, 1'b0, 8'd9, 32'h0, 32'hBBBB0009, 1'b0);

    // Reset while idle clears outputs but keeps RAM.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_data_out", b2.data_out, 32'd0);
    chk("rst2_ack", 32'(b2.ack), 32'd0);
    chk("rst2_busy", 32'(b2.busy), 32'd0);
    chk("rst2_err", 32'(b2.err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(2, 1'b0, 8'd5, 32'h0, 32'hDEADBEEF, 1'b0);

    repeat (2) @(negedge clk);
    chk("dut2_queue_drained", 32'(q2.size()), 32'd0);
    chk("dut0_queue_drained", 32'(q0.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
